// File: rtl/rpn_sequencer.sv
// Token-stream initiator for the RPN calculator push/op port.
// Mirrors the calculator stack depth to reject bad expressions before issuing them.
module rpn_sequencer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 10,
  parameter int unsigned DEPTH_MAX = 1023
) (
  input  logic              step,
  input  logic              rst,
  input  logic              start,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [1:0]        tok_kind,
  input  logic [DATA_W-1:0] tok_data,
  input  logic              tok_last,
  output logic              calc_nrst,
  output logic              calc_push,
  output logic [1:0]        calc_op,
  output logic [DATA_W-1:0] calc_d,
  input  logic [DATA_W-1:0] calc_out,
  input  logic [CNT_W-1:0]  calc_cnt,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              error,
  output logic [2:0]        err_code
);

  localparam logic [CNT_W-1:0] DMAX = CNT_W'(DEPTH_MAX);

  localparam logic [1:0] K_PUSH = 2'd0;
  localparam logic [1:0] K_NEG  = 2'd1;
  localparam logic [1:0] K_ADD  = 2'd2;
  localparam logic [1:0] K_MUL  = 2'd3;

  localparam logic [2:0] E_NONE   = 3'd0;
  localparam logic [2:0] E_UNDER  = 3'd1;
  localparam logic [2:0] E_OVER   = 3'd2;
  localparam logic [2:0] E_UNBAL  = 3'd3;
  localparam logic [2:0] E_DESYNC = 3'd4;

  // DRAIN holds the last command on the bus; CAP1 lets the calculator settle; CAP2 checks.
  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_RUN, S_DRAIN, S_CAP1, S_CAP2, S_ERR
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   depth_q, depth_d;
  logic               tok_ready_q, tok_ready_d;
  logic               calc_nrst_q, calc_nrst_d;
  logic               calc_push_q, calc_push_d;
  logic [1:0]         calc_op_q, calc_op_d;
  logic [DATA_W-1:0]  calc_d_q, calc_d_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [DATA_W-1:0]  result_q, result_d;
  logic               error_q, error_d;
  logic [2:0]         err_code_q, err_code_d;

  logic               accept;
  logic               illegal;
  logic [2:0]         tok_err;

  assign accept = tok_ready_q & tok_valid;

  // Depth screening of the presented token.
  always_comb begin
    illegal = 1'b0;
    tok_err = E_NONE;
    unique case (tok_kind)
      K_PUSH: if (depth_q == DMAX) begin
        illegal = 1'b1;
        tok_err = E_OVER;
      end
      K_NEG: if (depth_q == '0) begin
        illegal = 1'b1;
        tok_err = E_UNDER;
      end
      default: if (depth_q < CNT_W'(2)) begin
        illegal = 1'b1;
        tok_err = E_UNDER;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    calc_push_d = 1'b0;
    calc_op_d   = 2'd0;
    calc_d_d    = calc_d_q;
    done_d      = 1'b0;
    result_d    = result_q;
    error_d     = error_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      S_IDLE, S_ERR: begin
        if (start) begin
          state_d    = S_CLR;
          error_d    = 1'b0;
          err_code_d = E_NONE;
          result_d   = '0;
        end
      end
      S_CLR: begin
        depth_d = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          if (illegal) begin
            state_d    = S_ERR;
            error_d    = 1'b1;
            err_code_d = tok_err;
          end else begin
            unique case (tok_kind)
              K_PUSH: begin
                calc_push_d = 1'b1;
                calc_d_d    = tok_data;
                depth_d     = depth_q + CNT_W'(1);
              end
              K_NEG: calc_op_d = K_NEG;
              K_ADD: begin
                calc_op_d = K_ADD;
                depth_d   = depth_q - CNT_W'(1);
              end
              K_MUL: begin
                calc_op_d = K_MUL;
                depth_d   = depth_q - CNT_W'(1);
              end
            endcase
            if (tok_last) state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: state_d = S_CAP1;
      S_CAP1:  state_d = S_CAP2;
      S_CAP2: begin
        if (depth_q != CNT_W'(1)) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = E_UNBAL;
        end else if (calc_cnt != depth_q) begin
          state_d    = S_ERR;
          error_d    = 1'b1;
          err_code_d = E_DESYNC;
        end else begin
          state_d  = S_IDLE;
          result_d = calc_out;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // State-decoded outputs are registered from the next state so they align with it.
    tok_ready_d = (state_d == S_RUN);
    calc_nrst_d = (state_d != S_CLR);
    busy_d      = (state_d == S_CLR) || (state_d == S_RUN) || (state_d == S_DRAIN) ||
                  (state_d == S_CAP1) || (state_d == S_CAP2);
  end

  always_ff @(posedge step) begin
    if (rst) begin
      state_q     <= S_IDLE;
      depth_q     <= '0;
      tok_ready_q <= 1'b0;
      calc_nrst_q <= 1'b0;
      calc_push_q <= 1'b0;
      calc_op_q   <= 2'd0;
      calc_d_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
      error_q     <= 1'b0;
      err_code_q  <= E_NONE;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      tok_ready_q <= tok_ready_d;
      calc_nrst_q <= calc_nrst_d;
      calc_push_q <= calc_push_d;
      calc_op_q   <= calc_op_d;
      calc_d_q    <= calc_d_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_q    <= result_d;
      error_q     <= error_d;
      err_code_q  <= err_code_d;
    end
  end

  assign tok_ready = tok_ready_q;
  assign calc_nrst = calc_nrst_q;
  assign calc_push = calc_push_q;
  assign calc_op   = calc_op_q;
  assign calc_d    = calc_d_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign error     = error_q;
  assign err_code  = err_code_q;

endmodule
